// File: rtl/chroma_encoder_gen.sv
// Composite chroma encoder: NCO subcarrier into a generated sine LUT, burst or
// per-pixel hue/gain chroma, optional PAL V-switch, summed with luma and clamped.
module chroma_encoder_gen #(
  parameter int NCO_W       = 16,
  parameter int NCO_INC     = 7331,
  parameter int PHASE_W     = 4,
  parameter int AMP_W       = 4,
  parameter int LUMA_W      = 4,
  parameter int OUT_W       = 4,
  parameter int GAIN_W      = 2,
  parameter int BURST_SHIFT = 2,
  parameter int BURST_OFS   = 0
) (
  input  logic               clk_2x,
  input  logic               reset,
  input  logic [LUMA_W-1:0]  luma_sync,
  input  logic               active,
  input  logic               cb,
  input  logic [PHASE_W-1:0] phase,
  input  logic [GAIN_W-1:0]  gain,
  input  logic               pal_en,
  input  logic               line_start,
  input  logic               burst_sync_en,
  output logic [OUT_W-1:0]   composite,
  output logic               vswitch
);
  localparam int N_PH  = 2**PHASE_W;
  localparam int PEAK  = 2**(AMP_W-1) - 1;
  localparam int SUM_W = ((LUMA_W + 1 > AMP_W) ? LUMA_W + 1 : AMP_W) + 1;
  localparam int GMAX  = 2**GAIN_W - 1;
  localparam int OMAX  = 2**OUT_W - 1;
  localparam logic [PHASE_W-1:0] BOFS = PHASE_W'(BURST_OFS);

  typedef struct packed {
    logic [LUMA_W-1:0] luma;
    logic              cb;
    logic              active;
    logic [GAIN_W-1:0] gain;
  } ctl_t;

  // Fixed-point (2^24) Taylor sine on the first quadrant, folded by symmetry.
  function automatic int sine_val(input int k);
    longint sc, pi_s, x, term, acc;
    int     a;
    bit     neg;
    sc   = longint'(1) << 24;
    pi_s = 52707179;
    a    = k % N_PH;
    neg  = 1'b0;
    if (a >= N_PH / 2) begin
      a   = a - N_PH / 2;
      neg = 1'b1;
    end
    if (a > N_PH / 4) a = N_PH / 2 - a;
    x    = (2 * pi_s * a) / N_PH;
    term = x;
    acc  = x;
    for (int i = 1; i < 10; i++) begin
      term = -((((term * x) / sc) * x) / sc) / (2 * i * (2 * i + 1));
      acc  = acc + term;
    end
    sine_val = int'((PEAK * acc + sc / 2) / sc);
    if (neg) sine_val = -sine_val;
  endfunction

  logic signed [AMP_W-1:0] lut [N_PH];

  generate
    for (genvar k = 0; k < N_PH; k++) begin : g_lut
      localparam logic signed [AMP_W-1:0] V = AMP_W'(sine_val(k));
      assign lut[k] = V;
    end
  endgenerate

  logic [NCO_W-1:0]   nco, nco_nxt;
  logic               cb_q;
  logic [PHASE_W-1:0] ofs, ofs_sel, phs_c;

  // S1 indexes with the NCO value being loaded this edge, so the burst's
  // first sample sees the zeroed phase but the pre-toggle vswitch.
  assign nco_nxt = (cb && !cb_q && burst_sync_en) ? '0 : nco + NCO_W'(NCO_INC);

  always_comb begin
    ofs = '0;
    if (cb)          ofs = BOFS;
    else if (active) ofs = phase;
    ofs_sel = vswitch ? ('0 - ofs) : ofs;
    phs_c   = nco_nxt[NCO_W-1 -: PHASE_W] + ofs_sel;
  end

  always_ff @(posedge clk_2x) begin
    if (reset) begin
      nco     <= '0;
      cb_q    <= 1'b0;
      vswitch <= 1'b0;
    end else begin
      nco  <= nco_nxt;
      cb_q <= cb;
      if (!pal_en)         vswitch <= 1'b0;
      else if (line_start) vswitch <= ~vswitch;
    end
  end

  logic [PHASE_W-1:0]      phs_s1;
  ctl_t                    ctl_s1, ctl_s2;
  logic signed [AMP_W-1:0] osc_s2, chroma_c, chroma_s3;
  logic [LUMA_W-1:0]       luma_s3;
  logic signed [SUM_W-1:0] sum_c, sum_s4;
  logic [OUT_W-1:0]        comp_c;

  always_comb begin
    chroma_c = '0;
    if (ctl_s2.cb)
      chroma_c = osc_s2 >>> BURST_SHIFT;
    else if (ctl_s2.active && ctl_s2.gain != '0)
      chroma_c = osc_s2 >>> (GMAX - int'(ctl_s2.gain));
  end

  assign sum_c = $signed({{(SUM_W-LUMA_W){1'b0}}, luma_s3})
               + $signed({{(SUM_W-AMP_W){chroma_s3[AMP_W-1]}}, chroma_s3});

  always_comb begin
    comp_c = '0;
    if (sum_s4 < 0)                 comp_c = '0;
    else if (int'(sum_s4) > OMAX)   comp_c = OUT_W'(OMAX);
    else                            comp_c = OUT_W'(int'(sum_s4));
  end

  always_ff @(posedge clk_2x) begin
    if (reset) begin
      phs_s1    <= '0;
      ctl_s1    <= '0;
      ctl_s2    <= '0;
      osc_s2    <= '0;
      chroma_s3 <= '0;
      luma_s3   <= '0;
      sum_s4    <= '0;
      composite <= '0;
    end else begin
      phs_s1    <= phs_c;
      ctl_s1    <= '{luma: luma_sync, cb: cb, active: active, gain: gain};
      osc_s2    <= lut[phs_s1];
      ctl_s2    <= ctl_s1;
      chroma_s3 <= chroma_c;
      luma_s3   <= ctl_s2.luma;
      sum_s4    <= sum_c;
      composite <= comp_c;
    end
  end

endmodule

// File: tb/tb_chroma_encoder_gen.sv
// Scoreboard bench for chroma_encoder_gen: driver queues hand-computed composite
// (due 4 edges after sampling) and vswitch (due right after sampling) values.
module tb_chroma_encoder_gen;
  logic       clk_2x = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] luma_sync = '0;
  logic       active = 1'b0;
  logic       cb = 1'b0;
  logic [3:0] phase = '0;
  logic [1:0] gain = '0;
  logic       pal_en = 1'b0;
  logic       line_start = 1'b0;
  logic       burst_sync_en = 1'b1;
  logic [3:0] composite;
  logic       vswitch;

  chroma_encoder_gen dut (
    .clk_2x(clk_2x), .reset(reset), .luma_sync(luma_sync), .active(active),
    .cb(cb), .phase(phase), .gain(gain), .pal_en(pal_en),
    .line_start(line_start), .burst_sync_en(burst_sync_en),
    .composite(composite), .vswitch(vswitch)
  );

  typedef struct { int cyc; int exp; } exp_t;
  exp_t sb[$];
  exp_t vq[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   done = 1'b0;
  bit   pal_cfg = 1'b0;

  int burst_exp [6]    = '{8, 8, 9, 9, 8, 8};
  int hi_exp    [9]    = '{15, 15, 12, 9, 8, 10, 15, 15, 15};
  int lo_exp    [9]    = '{6, 3, 0, 0, 0, 0, 0, 5, 7};
  int gexp      [4][8] = '{'{8, 8, 8, 8, 8, 8, 8, 8},
                           '{8, 9, 9, 8, 8, 6, 6, 6},
                           '{9, 11, 11, 9, 8, 5, 4, 5},
                           '{11, 14, 14, 11, 8, 3, 1, 3}};
  int mix_g     [8]    = '{3, 3, 0, 0, 2, 2, 1, 1};
  int mix_exp   [8]    = '{11, 14, 8, 8, 8, 5, 6, 6};

  always #5 clk_2x = ~clk_2x;
  always @(posedge clk_2x) cyc <= cyc + 1;

  always @(negedge clk_2x) begin : mon
    exp_t e;
    if (sb.size() > 0 && sb[0].cyc + 4 <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (e.cyc + 4 != cyc || composite !== 4'(e.exp)) begin
        failures++;
        $display("FAIL composite stamp=%0d cyc=%0d got=%0d exp=%0d", e.cyc, cyc, composite, e.exp);
      end
    end
    if (vq.size() > 0 && vq[0].cyc <= cyc) begin
      e = vq.pop_front();
      checks++;
      if (e.cyc != cyc || vswitch !== e.exp[0]) begin
        failures++;
        $display("FAIL vswitch stamp=%0d cyc=%0d got=%0d exp=%0d", e.cyc, cyc, vswitch, e.exp);
      end
    end
    if (done) begin
      if (sb.size() != 0 || vq.size() != 0) begin
        failures++;
        $display("FAIL drain pending_composite=%0d pending_vswitch=%0d exp=0", sb.size(), vq.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  // One input vector per cycle; e = composite due 4 edges later, vs = vswitch right after sampling.
  task automatic step(input bit rst, input bit c, input bit a, input int ph, input int g,
                      input int l, input bit ls, input int e, input int vs);
    @(posedge clk_2x);
    #1;
    reset      = rst;
    cb         = c;
    active     = a;
    phase      = 4'(ph);
    gain       = 2'(g);
    luma_sync  = 4'(l);
    line_start = ls;
    pal_en     = pal_cfg;
    if (rst)
      foreach (sb[i]) if (sb[i].cyc >= cyc + 1 - 4) sb[i].exp = 0;
    sb.push_back('{cyc + 1, rst ? 0 : e});
    vq.push_back('{cyc + 1, vs});
  endtask

  task automatic idle(input int vs);
    step(1'b0, 1'b0, 1'b0, 0, 0, 8, 1'b0, 8, vs);
  endtask

  task automatic burst(input int l, input int e, input bit ls, input int vs);
    step(1'b0, 1'b1, 1'b0, 0, 0, l, ls, e, vs);
  endtask

  task automatic act(input int ph, input int g, input int l, input bit ls, input int e, input int vs);
    step(1'b0, 1'b0, 1'b1, ph, g, l, ls, e, vs);
  endtask

  initial begin
    repeat (3) step(1'b1, 1'b0, 1'b0, 0, 0, 8, 1'b0, 0, 0);
    repeat (6) idle(0);

    foreach (burst_exp[i]) burst(8, burst_exp[i], 1'b0, 0);
    idle(0);

    burst(15, 15, 1'b0, 0);
    foreach (hi_exp[i]) act(4, 3, 15, 1'b0, hi_exp[i], 0);
    idle(0);
    burst(0, 0, 1'b0, 0);
    foreach (lo_exp[i]) act(4, 3, 0, 1'b0, lo_exp[i], 0);
    idle(0);

    for (int g = 3; g >= 0; g--) begin
      burst(8, 8, 1'b0, 0);
      for (int k = 0; k < 8; k++) act(0, g, 8, 1'b0, gexp[g][k], 0);
      idle(0);
    end
    burst(8, 8, 1'b0, 0);
    foreach (mix_g[k]) act(0, mix_g[k], 8, 1'b0, mix_exp[k], 0);
    idle(0);

    pal_cfg = 1'b1;
    idle(0);
    burst(8, 8, 1'b1, 1);
    act(2, 3, 8, 1'b0, 5, 1);
    act(2, 3, 8, 1'b0, 11, 1);
    act(2, 3, 8, 1'b0, 14, 1);
    act(2, 3, 8, 1'b0, 14, 1);
    idle(1);
    burst(8, 8, 1'b1, 0);
    act(2, 3, 8, 1'b0, 14, 0);
    act(2, 3, 8, 1'b0, 14, 0);
    act(2, 3, 8, 1'b0, 11, 0);
    act(2, 3, 8, 1'b0, 5, 0);
    idle(0);
    burst(8, 8, 1'b0, 0);
    act(2, 3, 8, 1'b1, 14, 1);
    act(2, 3, 8, 1'b0, 11, 1);
    act(2, 3, 8, 1'b0, 14, 1);
    act(2, 3, 8, 1'b0, 14, 1);
    idle(1);
    pal_cfg = 1'b0;
    idle(0);
    step(1'b0, 1'b0, 1'b0, 0, 0, 8, 1'b1, 8, 0);
    idle(0);

    // Reset for one cycle in the middle of a burst with vswitch set.
    pal_cfg = 1'b1;
    step(1'b0, 1'b0, 1'b0, 0, 0, 8, 1'b1, 8, 1);
    idle(1);
    burst(8, 8, 1'b0, 1);
    burst(8, 8, 1'b0, 1);
    burst(8, 9, 1'b0, 1);
    step(1'b1, 1'b1, 1'b0, 0, 0, 8, 1'b0, 0, 0);
    burst(8, 8, 1'b0, 0);
    burst(8, 8, 1'b0, 0);
    burst(8, 9, 1'b0, 0);
    burst(8, 9, 1'b0, 0);
    idle(0);
    pal_cfg = 1'b0;
    idle(0);

    repeat (10) @(posedge clk_2x);
    done = 1'b1;
  end
endmodule
